// File: rtl/rdma_cq_region_buf_if.sv
// Completion stream bundle between the RDMA arbiter, the region buffer and user logic.
// Latency: none (wires only).
// Backpressure: s_cq_* has no ready; m_cq_* is valid/ready.
// Ports: s_cq_valid/s_cq_data (arbiter -> buffer), m_cq_valid/m_cq_data/m_cq_ready (buffer <-> user).
interface rdma_cq_region_buf_if #(
   parameter int DATA_BITS = 64
);
   logic                 s_cq_valid;
   logic [DATA_BITS-1:0] s_cq_data;
   logic                 m_cq_valid;
   logic                 m_cq_ready;
   logic [DATA_BITS-1:0] m_cq_data;

   // The buffer itself: takes the arbiter stream, serves the user stream.
   modport slave (
      input  s_cq_valid,
      input  s_cq_data,
      input  m_cq_ready,
      output m_cq_valid,
      output m_cq_data
   );

   // Whoever drives completions in and consumes them out.
   modport master (
      output s_cq_valid,
      output s_cq_data,
      output m_cq_ready,
      input  m_cq_valid,
      input  m_cq_data
   );
endinterface

// File: rtl/rdma_cq_region_buf.sv
// Per-region RDMA completion buffer: absorbs a ready-less CQ stream into a FIFO, serves it valid/ready.
// Latency: 1 cycle push-to-m_cq_valid when empty; m_cq_data is registered, no comb path s->m.
// Backpressure: none upstream; completions arriving while full (and not popping) are dropped and counted.
// Ports: aclk/aresetn; cq (slave modport) carries s_cq_* in and m_cq_* out; clear_stats pulse clears
//        drop_cnt/overflow and reloads hwm; occupancy/hwm report entries held; drop_cnt saturates; overflow sticky.
module rdma_cq_region_buf #(
   parameter int DATA_BITS = 64,
   parameter int DEPTH     = 16,
   parameter int CNT_BITS  = 16
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   rdma_cq_region_buf_if.slave      cq,
   input  logic                     clear_stats,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic [$clog2(DEPTH):0]   hwm,
   output logic [CNT_BITS-1:0]      drop_cnt,
   output logic                     overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;

   // The output register is one of the DEPTH entries, so the array never holds more than DEPTH-1.
   logic [DATA_BITS-1:0] mem [DEPTH];
   logic [AW:0]          wptr;
   logic [AW:0]          rptr;
   logic                 out_vld;
   logic [DATA_BITS-1:0] out_dat;

   logic                 full;
   logic                 mem_empty;
   logic                 pop;
   logic                 push;
   logic                 drop;
   logic                 load;
   logic                 bypass;
   logic [OW-1:0]        occ_nxt;
   logic [OW-1:0]        hwm_nxt;

   assign full      = (occupancy == OW'(DEPTH));
   assign mem_empty = (wptr == rptr);
   assign pop       = out_vld && cq.m_cq_ready;
   // A pop in the same cycle frees the slot, so full-with-pop still accepts.
   assign push      = cq.s_cq_valid && (!full || pop);
   assign drop      = cq.s_cq_valid && full && !pop;
   // Output register can take a new word when it is empty or being drained this cycle.
   assign load      = !out_vld || pop;
   // Nothing queued behind the output register: new word goes straight into it.
   assign bypass    = push && mem_empty && load;
   assign occ_nxt   = occupancy + OW'(push) - OW'(pop);
   assign hwm_nxt   = clear_stats ? occ_nxt : ((occ_nxt > hwm) ? occ_nxt : hwm);

   assign cq.m_cq_valid = out_vld;
   assign cq.m_cq_data  = out_dat;

   // Storage array carries no reset; contents are only read behind valid pointers.
   always_ff @(posedge aclk) begin
      if (push && !bypass) begin
         mem[wptr[AW-1:0]] <= cq.s_cq_data;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wptr      <= '0;
         rptr      <= '0;
         out_vld   <= 1'b0;
         out_dat   <= '0;
         occupancy <= '0;
         hwm       <= '0;
         drop_cnt  <= '0;
         overflow  <= 1'b0;
      end else begin
         if (push && !bypass) begin
            wptr <= wptr + 1'b1;
         end

         if (load) begin
            if (!mem_empty) begin
               out_dat <= mem[rptr[AW-1:0]];
               rptr    <= rptr + 1'b1;
               out_vld <= 1'b1;
            end else if (push) begin
               out_dat <= cq.s_cq_data;
               out_vld <= 1'b1;
            end else begin
               out_vld <= 1'b0;
            end
         end

         occupancy <= occ_nxt;
         hwm       <= hwm_nxt;

         // A drop coinciding with clear_stats survives the clear as a count of one.
         if (clear_stats) begin
            drop_cnt <= drop ? CNT_BITS'(1) : '0;
            overflow <= drop;
         end else if (drop) begin
            if (!(&drop_cnt)) begin
               drop_cnt <= drop_cnt + 1'b1;
            end
            overflow <= 1'b1;
         end
      end
   end
endmodule
